hmulti_null_sink: RTL and testbench

- Parametrised successor to the single-channel null sink.
- Terminates NUM_CHNLS independent 4-phase req/ack input channels at one local address.
- Per channel: debounces req, checks destination, optionally delays ack, and keeps a saturating message counter and an XOR data checksum.
- Latches the first address error for debug; used as an end-of-network sink and a traffic monitor in hgen_net test fabrics.

---
 rtl/hmulti_null_sink_pkg.sv | 18 +
 rtl/hmulti_null_sink_chnl.sv | 103 ++++++++++
 rtl/hmulti_null_sink.sv | 97 +++++++++
 tb/tb_hmulti_null_sink.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hmulti_null_sink_pkg.sv
// Shared sink constants: on/off levels, default address/data widths and channel FSM encodings.
package hmulti_null_sink_pkg;

    localparam logic NS_ON  = 1'b1;
    localparam logic NS_OFF = 1'b0;

    localparam int NS_ADDRESS_SIZE = 8;
    localparam int NS_DATA_SIZE    = 8;
    localparam int NS_REQ_CKS      = 2;

    typedef enum logic [1:0] {
        HMS_IDLE = 2'd0,
        HMS_WAIT = 2'd1,
        HMS_ACK  = 2'd2,
        HMS_ERR  = 2'd3
    } hms_state_t;

endpackage

// File: rtl/hmulti_null_sink_chnl.sv
// One sink channel: req debouncer, 4-phase handshake FSM with optional ack delay,
// saturating message counter and XOR checksum. err_stb pulses on a dst mismatch.
module hmulti_sink_chnl
    import hmulti_null_sink_pkg::*;
#(
    parameter int MY_LOCAL_ADDR = 0,
    parameter int ASZ           = NS_ADDRESS_SIZE,
    parameter int DSZ           = NS_DATA_SIZE,
    parameter int CSZ           = 16,
    parameter int REQ_CKS       = NS_REQ_CKS,
    parameter int ACK_DELAY     = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           ready,
    input  logic           clr,
    input  logic           req,
    input  logic [ASZ-1:0] dst,
    input  logic [DSZ-1:0] dat,
    output logic           ack,
    output logic [CSZ-1:0] cnt,
    output logic [DSZ-1:0] cks,
    output logic           err_stb
);

    localparam int DW = (REQ_CKS > 1) ? $clog2(REQ_CKS) : 1;
    localparam logic [DW-1:0] DEB_MAX  = DW'(REQ_CKS - 1);
    localparam logic [7:0]    DLY_LOAD = (ACK_DELAY > 0) ? 8'(ACK_DELAY - 1) : 8'd0;

    hms_state_t    state;
    hms_state_t    state_nxt;
    logic          ckd_req;
    logic [DW-1:0] deb;
    logic [7:0]    dly;
    logic          accept;

    // ckd_req rises on the REQ_CKS-th consecutive high sample and falls on the first low one
    always_ff @(posedge clk) begin
        if (reset) begin
            deb     <= '0;
            ckd_req <= NS_OFF;
        end else if (!req) begin
            deb     <= '0;
            ckd_req <= NS_OFF;
        end else if (deb < DEB_MAX) begin
            deb <= deb + 1'b1;
        end else begin
            ckd_req <= NS_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HMS_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        err_stb   = 1'b0;
        if (ready) begin
            case (state)
                HMS_IDLE: if (ckd_req) begin
                    if (dst == ASZ'(MY_LOCAL_ADDR)) begin
                        accept    = 1'b1;
                        state_nxt = (ACK_DELAY == 0) ? HMS_ACK : HMS_WAIT;
                    end else begin
                        err_stb   = 1'b1;
                        state_nxt = HMS_ERR;
                    end
                end
                // a withdrawn req does not cut the delay short; ACK then drops it after one cycle
                HMS_WAIT: if (dly == 8'd0) state_nxt = HMS_ACK;
                HMS_ACK:  if (!ckd_req) state_nxt = HMS_IDLE;
                HMS_ERR:  if (!ckd_req) state_nxt = HMS_IDLE;
                default:  state_nxt = HMS_IDLE;
            endcase
        end
    end

    assign ack = (state == HMS_ACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            dly <= 8'd0;
        end else if (ready) begin
            if (accept)                                 dly <= DLY_LOAD;
            else if (state == HMS_WAIT && dly != 8'd0) dly <= dly - 8'd1;
        end
    end

    // clr outranks a same-cycle accept: the message is acked but not counted
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
            cks <= '0;
        end else if (accept) begin
            if (cnt != {CSZ{1'b1}}) cnt <= cnt + 1'b1;
            cks <= cks ^ dat;
        end
    end

endmodule

// File: rtl/hmulti_null_sink.sv
// Multi-channel null sink: NUM_CHNLS independent req/ack terminators at one address,
// plus ready sequencing and a first-error latch (lowest channel wins ties).
module hmulti_null_sink
    import hmulti_null_sink_pkg::*;
#(
    parameter int MY_LOCAL_ADDR = 0,
    parameter int ASZ           = NS_ADDRESS_SIZE,
    parameter int DSZ           = NS_DATA_SIZE,
    parameter int NUM_CHNLS     = 4,
    parameter int CSZ           = 16,
    parameter int REQ_CKS       = NS_REQ_CKS,
    parameter int ACK_DELAY     = 0
) (
    input  logic                     gch_clk,
    input  logic                     gch_reset,
    output logic                     gch_ready,
    input  logic                     clr,
    input  logic [NUM_CHNLS-1:0]     rcv_req,
    output logic [NUM_CHNLS-1:0]     rcv_ack_out,
    input  logic [NUM_CHNLS*ASZ-1:0] rcv_dst,
    input  logic [NUM_CHNLS*DSZ-1:0] rcv_dat,
    output logic [NUM_CHNLS*CSZ-1:0] cnt_out,
    output logic [NUM_CHNLS*DSZ-1:0] cks_out,
    output logic                     err_flag,
    output logic [3:0]               err_chnl,
    output logic [ASZ-1:0]           err_dst,
    output logic [DSZ-1:0]           err_dat
);

    logic           init_q;
    logic [NUM_CHNLS-1:0] err_stb;
    logic [3:0]     first_idx;
    logic [ASZ-1:0] first_dst;
    logic [DSZ-1:0] first_dat;

    // one init cycle after reset release before channels may act
    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            init_q    <= NS_OFF;
            gch_ready <= NS_OFF;
        end else begin
            init_q    <= NS_ON;
            gch_ready <= init_q;
        end
    end

    for (genvar i = 0; i < NUM_CHNLS; i++) begin : g_chnl
        hmulti_sink_chnl #(
            .MY_LOCAL_ADDR(MY_LOCAL_ADDR),
            .ASZ          (ASZ),
            .DSZ          (DSZ),
            .CSZ          (CSZ),
            .REQ_CKS      (REQ_CKS),
            .ACK_DELAY    (ACK_DELAY)
        ) u_chnl (
            .clk    (gch_clk),
            .reset  (gch_reset),
            .ready  (gch_ready),
            .clr    (clr),
            .req    (rcv_req[i]),
            .dst    (rcv_dst[i*ASZ +: ASZ]),
            .dat    (rcv_dat[i*DSZ +: DSZ]),
            .ack    (rcv_ack_out[i]),
            .cnt    (cnt_out[i*CSZ +: CSZ]),
            .cks    (cks_out[i*DSZ +: DSZ]),
            .err_stb(err_stb[i])
        );
    end

    always_comb begin
        first_idx = '0;
        first_dst = '0;
        first_dat = '0;
        for (int i = NUM_CHNLS - 1; i >= 0; i--) begin
            if (err_stb[i]) begin
                first_idx = 4'(i);
                first_dst = rcv_dst[i*ASZ +: ASZ];
                first_dat = rcv_dat[i*DSZ +: DSZ];
            end
        end
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset || clr) begin
            err_flag <= NS_OFF;
            err_chnl <= '0;
            err_dst  <= '0;
            err_dat  <= '0;
        end else if (!err_flag && (|err_stb)) begin
            err_flag <= NS_ON;
            err_chnl <= first_idx;
            err_dst  <= first_dst;
            err_dat  <= first_dat;
        end
    end

endmodule

// File: tb/tb_hmulti_null_sink.sv
// Directed bench: dut a (CSZ=4, no ack delay) and dut b (ACK_DELAY=3), REQ_CKS=2 on both.
module tb_hmulti_null_sink;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    logic        a_ready, a_clr, a_err_flag;
    logic [3:0]  a_req, a_ack, a_err_chnl;
    logic [31:0] a_dst, a_dat, a_cks;
    logic [15:0] a_cnt;
    logic [7:0]  a_err_dst, a_err_dat;

    logic        b_ready, b_clr, b_err_flag;
    logic [3:0]  b_req, b_ack, b_err_chnl;
    logic [31:0] b_dst, b_dat, b_cks;
    logic [63:0] b_cnt;
    logic [7:0]  b_err_dst, b_err_dat;

    logic [7:0]  xs;
    logic [7:0]  d;

    always #5 clk = ~clk;

    hmulti_null_sink #(.MY_LOCAL_ADDR(0), .ASZ(8), .DSZ(8), .NUM_CHNLS(4), .CSZ(4),
                       .REQ_CKS(2), .ACK_DELAY(0)) dut_a (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(a_ready), .clr(a_clr),
        .rcv_req(a_req), .rcv_ack_out(a_ack), .rcv_dst(a_dst), .rcv_dat(a_dat),
        .cnt_out(a_cnt), .cks_out(a_cks), .err_flag(a_err_flag), .err_chnl(a_err_chnl),
        .err_dst(a_err_dst), .err_dat(a_err_dat));

    hmulti_null_sink #(.MY_LOCAL_ADDR(0), .ASZ(8), .DSZ(8), .NUM_CHNLS(4), .CSZ(16),
                       .REQ_CKS(2), .ACK_DELAY(3)) dut_b (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(b_ready), .clr(b_clr),
        .rcv_req(b_req), .rcv_ack_out(b_ack), .rcv_dst(b_dst), .rcv_dat(b_dat),
        .cnt_out(b_cnt), .cks_out(b_cks), .err_flag(b_err_flag), .err_chnl(b_err_chnl),
        .err_dst(b_err_dst), .err_dat(b_err_dat));

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_clr = 1'b0; a_req = '0; a_dst = '0; a_dat = '0;
        b_clr = 1'b0; b_req = '0; b_dst = '0; b_dat = '0;
        tick(3);
        chk("rst_ready", {63'd0, a_ready}, 64'd0);
        chk("rst_ack", {60'd0, a_ack}, 64'd0);
        chk("rst_cnt", {48'd0, a_cnt}, 64'd0);
        chk("rst_cks", {32'd0, a_cks}, 64'd0);
        chk("rst_err", {63'd0, a_err_flag}, 64'd0);

        rst = 1'b0;
        tick(1);
        chk("init_ready", {63'd0, a_ready}, 64'd0);
        tick(1);
        chk("ready_up", {63'd0, a_ready}, 64'd1);
        tick(1);

        // ch0 message 1: ack two edges after req is first sampled
        a_req[0] = 1'b1; a_dat[7:0] = 8'hA5;
        tick(2);
        chk("m1_ack_early", {60'd0, a_ack}, 64'd0);
        tick(1);
        chk("m1_ack", {60'd0, a_ack}, 64'd1);
        a_req[0] = 1'b0;
        tick(1);
        chk("m1_ack_hold", {60'd0, a_ack}, 64'd1);
        tick(1);
        chk("m1_ack_fall", {60'd0, a_ack}, 64'd0);

        a_req[0] = 1'b1; a_dat[7:0] = 8'h5A;
        tick(3);
        chk("m2_ack", {60'd0, a_ack}, 64'd1);
        chk("m2_cnt", {48'd0, a_cnt}, 64'h0002);
        chk("m2_cks", {32'd0, a_cks}, 64'h0000_00FF);
        a_req[0] = 1'b0;
        tick(2);

        // simultaneous errors on ch1 and ch3
        a_dst = {8'd7, 8'd0, 8'd5, 8'd0};
        a_dat = {8'h77, 8'h00, 8'h33, 8'h00};
        a_req = 4'b1010;
        tick(3);
        chk("err_noack", {60'd0, a_ack}, 64'd0);
        chk("err_flag", {63'd0, a_err_flag}, 64'd1);
        chk("err_chnl", {60'd0, a_err_chnl}, 64'd1);
        chk("err_dst", {56'd0, a_err_dst}, 64'd5);
        chk("err_dat", {56'd0, a_err_dat}, 64'h33);
        a_req = '0;
        tick(2);

        // a later error must not overwrite the latch
        a_dst = {8'd0, 8'd0, 8'd0, 8'd9};
        a_dat = {8'h00, 8'h00, 8'h00, 8'hEE};
        a_req[0] = 1'b1;
        tick(3);
        chk("err2_noack", {60'd0, a_ack}, 64'd0);
        chk("err2_chnl", {60'd0, a_err_chnl}, 64'd1);
        chk("err2_dst", {56'd0, a_err_dst}, 64'd5);
        a_req[0] = 1'b0;
        tick(2);
        a_dst = '0;

        // 20 more messages on ch0: 4-bit counter saturates at 15
        xs = 8'hFF;
        for (int m = 0; m < 20; m++) begin
            d = 8'(m * 37 + 11);
            xs = xs ^ d;
            a_dat[7:0] = d;
            a_req[0] = 1'b1;
            tick(3);
            if (m == 0 || m == 19) chk("sat_ack", {60'd0, a_ack}, 64'd1);
            a_req[0] = 1'b0;
            tick(2);
        end
        chk("sat_cnt", {48'd0, a_cnt}, 64'h000F);
        chk("sat_cks", {32'd0, a_cks}, {56'd0, xs});

        // clr in the accept cycle: not counted, handshake still completes
        a_dat[7:0] = 8'h11;
        a_req[0] = 1'b1;
        tick(2);
        a_clr = 1'b1;
        tick(1);
        a_clr = 1'b0;
        chk("clr_ack", {60'd0, a_ack}, 64'd1);
        chk("clr_cnt", {48'd0, a_cnt}, 64'd0);
        chk("clr_cks", {32'd0, a_cks}, 64'd0);
        chk("clr_err", {63'd0, a_err_flag}, 64'd0);
        a_req[0] = 1'b0;
        tick(2);
        chk("clr_ack_fall", {60'd0, a_ack}, 64'd0);

        // dut b ch2 with ACK_DELAY=3: ack at req+REQ_CKS+3 edges
        b_dat = {8'h00, 8'h3C, 8'h00, 8'h00};
        b_req[2] = 1'b1;
        tick(3);
        chk("dly_cnt_accept", b_cnt, 64'h0000_0001_0000_0000);
        tick(1);
        chk("dly_ack_e3", {60'd0, b_ack}, 64'd0);
        tick(1);
        chk("dly_ack_e4", {60'd0, b_ack}, 64'd0);
        tick(1);
        chk("dly_ack", {60'd0, b_ack}, 64'b0100);
        b_req[2] = 1'b0;
        tick(1);
        chk("dly_ack_hold", {60'd0, b_ack}, 64'b0100);
        tick(1);
        chk("dly_ack_fall", {60'd0, b_ack}, 64'd0);
        chk("dly_cks", {32'd0, b_cks}, 64'h003C_0000);
        tick(1);

        // req withdrawn during WAIT: one-cycle ack pulse
        b_req[2] = 1'b1;
        tick(3);
        b_req[2] = 1'b0;
        tick(2);
        chk("wd_ack_pre", {60'd0, b_ack}, 64'd0);
        tick(1);
        chk("wd_pulse", {60'd0, b_ack}, 64'b0100);
        tick(1);
        chk("wd_pulse_end", {60'd0, b_ack}, 64'd0);
        chk("wd_cnt", b_cnt, 64'h0000_0002_0000_0000);
        tick(1);

        // reset while ch2 ack is high
        b_dat = {8'h00, 8'h0F, 8'h00, 8'h00};
        b_req[2] = 1'b1;
        tick(6);
        chk("rack_ack", {60'd0, b_ack}, 64'b0100);
        rst = 1'b1;
        tick(1);
        chk("rack_drop", {60'd0, b_ack}, 64'd0);
        chk("rack_cnt", b_cnt, 64'd0);
        chk("rack_cks", {32'd0, b_cks}, 64'd0);
        chk("rack_ready", {63'd0, b_ready}, 64'd0);
        b_req = '0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
